// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_WIDTH = 32;

  // Counter wide enough to hold WIDTH-1 with headroom.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_WIDTH = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/div_sub_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           unused_diff_msb;

  // rem_in < divisor always holds, so shifted < 2*divisor and a successful
  // subtraction always fits back into WIDTH bits.
  assign shifted         = {rem_in, next_bit};
  assign diff            = shifted - {1'b0, divisor};
  assign quo_bit         = (shifted >= {1'b0, divisor});
  assign rem_out         = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider: WIDTH shift-subtract steps on operand
// magnitudes, then one cycle of sign correction before a one-cycle done.
// Define DIV_SIGNED_EN to enable two's-complement operation via is_signed;
// without it every division is unsigned and is_signed is ignored.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_bits(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_step;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;            // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] dividend_hold;  // original dividend, returned on divide-by-zero
  logic             zero_div;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == CALC) || (state == FIX);
  assign done      = (state == DONE);

`ifdef DIV_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  // Negating a zero magnitude quotient leaves it zero, so no extra guard.
  assign quo_fixed    = neg_quo ? -acc      : acc;
  assign rem_fixed    = neg_rem ? -part_rem : part_rem;

  // Capture the result signs together with the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_quo <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem <= is_signed && dividend[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;

  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
  assign quo_fixed        = acc;
  assign rem_fixed        = part_rem;
  assign unused_is_signed = is_signed;
`endif

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (part_rem),
    .next_bit (acc[WIDTH-1]),
    .divisor  (div_mag),
    .rem_out  (step_rem),
    .quo_bit  (step_bit)
  );

  // State register; reset returns to IDLE immediately.
  // NOTE: sequential logic uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  // NOTE: state_next gets a default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (divisor == '0) ? FIX : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift-subtract step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      acc           <= '0;
      part_rem      <= '0;
      div_mag       <= '0;
      dividend_hold <= '0;
      zero_div      <= 1'b0;
    end else if (accept) begin
      cnt           <= '0;
      acc           <= dividend_mag;
      part_rem      <= '0;
      div_mag       <= divisor_mag;
      dividend_hold <= dividend;
      zero_div      <= (divisor == '0);
    end else if (state == CALC) begin
      cnt      <= cnt + CW'(1);
      acc      <= {acc[WIDTH-2:0], step_bit};
      part_rem <= step_rem;
    end
  end

  // Result registers load only on leaving FIX and hold until the next FIX.
  // NOTE: these are reset explicitly because they drive the outputs, which
  // must read zero throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == FIX) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend_hold;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= quo_fixed;
        remainder   <= rem_fixed;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (WIDTH=32). A behavioural model
// computes results with plain integer division and tracks when done must
// appear; a monitor compares every output on every falling edge. Directed
// vectors additionally pin hand-computed results and latencies.
module tb_iterative_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model state: what the outputs must be in the current cycle.
  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_done_at;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q_signed;
    logic [W-1:0] r_signed;
    logic [W-1:0] q_unsigned;
    logic [W-1:0] r_unsigned;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs [9];

  iterative_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Truncating division from the arithmetic definition.
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic dz);
    longint sa, sb;
    logic   s_eff;
`ifdef DIV_SIGNED_EN
    s_eff = s;
`else
    s_eff = s & 1'b0;
`endif
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (s_eff) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_dz   = 1'b0;
    m_q    = '0;
    m_r    = '0;
  endtask

  // Advance the model across one rising edge using the sampled inputs.
  task automatic model_edge();
    logic prev_busy;
    prev_busy = m_busy;
    m_done    = 1'b0;
    if (m_busy && cyc == m_done_at) begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_q    = p_q;
      m_r    = p_r;
      m_dz   = p_dz;
    end
    if (start && !prev_busy) begin
      model_div(dividend, divisor, is_signed, p_q, p_r, p_dz);
      m_busy    = 1'b1;
      m_done_at = cyc + ((divisor == 0) ? 1 : W + 1);
    end
  endtask

  // Monitor: update the model on rising edges, compare on falling edges.
  initial begin
    model_reset();
    p_q = '0; p_r = '0; p_dz = 1'b0; m_done_at = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_edge();
      @(negedge clk);
      if (rst) model_reset();
      check("mon_busy", 32'(busy), 32'(m_busy));
      check("mon_done", 32'(done), 32'(m_done));
      check("mon_quotient", quotient, m_q);
      check("mon_remainder", remainder, m_r);
      check("mon_div_by_zero", 32'(div_by_zero), 32'(m_dz));
    end
  end

  // Present operands for one cycle; returns the accepting edge number.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int acc);
    @(posedge clk);
    #2;
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk);
    #1 acc = cyc;
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; latency counts edges up to the one that samples it.
  task automatic await_done(input int acc, output int lat, output logic found);
    found = 1'b0;
    lat   = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL done_timeout: no done within 200 cycles of accept at cycle %0d", acc);
    end else begin
      lat = cyc + 1 - acc;
    end
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz, input int lat_exp, input int lat, input logic found);
    if (found) begin
      check({name, "_quotient"}, quotient, q);
      check({name, "_remainder"}, remainder, r);
      check({name, "_div_by_zero"}, 32'(div_by_zero), 32'(dz));
      check({name, "_latency"}, 32'(lat), 32'(lat_exp));
    end
  endtask

  initial begin
    int   acc, acc2, lat;
    logic found;
    logic [W-1:0] eq, er;

    vecs = '{
      '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          32'd14,         32'd2,          1'b0, 34},
      '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0, 34},
      '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  32'h7FFF_FFFC,  32'd1,          1'b0, 34},
      '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234,       32'hFFFF_FFFF,  32'd1234,       1'b1, 2},
      '{32'hFFFF_FF00,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FF00,  32'hFFFF_FFFF,  32'hFFFF_FF00,  1'b1, 2},
      '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          32'd0,          32'h8000_0000,  1'b0, 34},
      '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  32'h2492_4916,  32'd2,          1'b0, 34},
      '{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          32'd0,          32'd100,        1'b0, 34},
      '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  32'd0,          32'hFFFF_FF9C,  1'b0, 34}
    };

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Directed table: spec vectors plus signed sign combinations.
    foreach (vecs[i]) begin
`ifdef DIV_SIGNED_EN
      eq = vecs[i].q_signed;   er = vecs[i].r_signed;
`else
      eq = vecs[i].q_unsigned; er = vecs[i].r_unsigned;
`endif
      launch(vecs[i].a, vecs[i].b, vecs[i].s, acc);
      await_done(acc, lat, found);
      expect_result($sformatf("vec%0d", i), eq, er, vecs[i].dz, vecs[i].lat, lat, found);
    end

    // A start arriving mid-operation must not disturb the division.
    launch(32'd50, 32'd3, 1'b0, acc);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; dividend = 32'd7; divisor = 32'd0;
    @(posedge clk);
    #2 start = 1'b0;
    await_done(acc, lat, found);
    expect_result("ignored_start", 32'd16, 32'd2, 1'b0, 34, lat, found);

    // Abort: start 1000/10, ignored start, then asynchronous reset.
    launch(32'd1000, 32'd10, 1'b0, acc);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; dividend = 32'd3; divisor = 32'd1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(posedge clk);
    // Start presented together with reset release: first edge must accept it.
    #2 rst = 1'b0; start = 1'b1; dividend = 32'd9; divisor = 32'd9; is_signed = 1'b0;
    @(posedge clk);
    #1 acc = cyc;
    #1 start = 1'b0;
    await_done(acc, lat, found);
    expect_result("restart", 32'd1, 32'd0, 1'b0, 34, lat, found);

    // Back-to-back: start during the DONE cycle of 15/15.
    launch(32'd15, 32'd15, 1'b0, acc);
    await_done(acc, lat, found);
    expect_result("b2b_first", 32'd1, 32'd0, 1'b0, 34, lat, found);
    start = 1'b1; dividend = 32'd5; divisor = 32'd1; is_signed = 1'b0;
    @(posedge clk);
    #1 acc2 = cyc;
    #1 start = 1'b0;
    await_done(acc2, lat, found);
    expect_result("b2b_second", 32'd5, 32'd0, 1'b0, 34, lat, found);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
